fpu_issue_ctrl: RTL and testbench

- Initiator side of the FPU start/done handshake. Sits between the pipeline's floating-point issue stage and the multi-cycle FPU.
- Accepts one FP request (A, B, op, destination register), launches the FPU with a one-cycle start pulse, waits for done, then presents the result for writeback.
- Aborts a hung FPU after a timeout and returns a flagged error result.

---
 rtl/fpu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// FPU start/done initiator: launch, wait with stale-done mask, timeout abort.
// Optional FPU_REUSE_EN adds a last-result cache that bypasses the FPU.
`timescale 1ns/1ps
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned CNT_W     = 9,
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_r,
  output logic        fpu_rst,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, ERR, WB
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             errTail;
  logic             cacheHit;
  logic [31:0]      hitData;

  assign req_ready = (state == IDLE);

`ifdef FPU_REUSE_EN
  logic        cacheVld;
  logic [1:0]  cacheOp;
  logic [31:0] cacheA;
  logic [31:0] cacheB;
  logic [31:0] cacheR;

  assign cacheHit = cacheVld && (cacheOp == req_op)
                 && (cacheA == req_a) && (cacheB == req_b);
  assign hitData  = cacheR;

  // Any FPU launch or abort drops the entry; a clean writeback refills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cacheVld <= 1'b0;
      cacheOp  <= '0;
      cacheA   <= '0;
      cacheB   <= '0;
      cacheR   <= '0;
    end else if (state == START || state == ERR) begin
      cacheVld <= 1'b0;
    end else if (state == WB && wb_ready && !wb_err) begin
      cacheVld <= 1'b1;
      cacheOp  <= fpu_op;
      cacheA   <= fpu_a;
      cacheB   <= fpu_b;
      cacheR   <= wb_data;
    end
  end
`else
  assign cacheHit = 1'b0;
  assign hitData  = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      errTail   <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      fpu_start <= 1'b0;
      fpu_rst   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            fpu_a  <= req_a;
            fpu_b  <= req_b;
            fpu_op <= req_op;
            wb_rd  <= req_rd;
            busy   <= 1'b1;
            if (cacheHit) begin
              wb_data  <= hitData;
              wb_err   <= 1'b0;
              wb_valid <= 1'b1;
              state    <= WB;
            end else begin
              fpu_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: begin
          fpu_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // cnt==0 is the first WAIT cycle: done there is a leftover level
          if (fpu_done && cnt != '0) begin
            wb_data  <= fpu_r;
            wb_err   <= 1'b0;
            wb_valid <= 1'b1;
            state    <= WB;
          end else if (cnt == CNT_LAST) begin
            fpu_rst <= 1'b1;
            wb_data <= NAN_VALUE;
            wb_err  <= 1'b1;
            errTail <= 1'b0;
            state   <= ERR;
          end
        end
        ERR: begin
          if (!errTail) begin
            errTail <= 1'b1;
          end else begin
            fpu_rst  <= 1'b0;
            wb_valid <= 1'b1;
            state    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: random requests, bench FPU model
// with stale done levels and hangs, queue-based writeback checking.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;

  localparam int          TMO = 16;
  localparam logic [31:0] NAN = 32'h7FC00000;
`ifdef FPU_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start, fpu_done, fpu_rst;
  logic [31:0] fpu_r;
  logic        wb_valid, wb_ready, wb_err, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  fpu_issue_ctrl #(.TIMEOUT(TMO), .CNT_W(9), .NAN_VALUE(NAN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_r(fpu_r),
    .fpu_rst(fpu_rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nVec = 0;
  int nFail = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          accept;
    int          lat;
    logic [1:0]  op;
    logic [31:0] a, b;
  } exp_t;

  typedef struct {
    logic        hang;
    int          d;
    logic [31:0] res;
    logic [1:0]  op;
    logic [31:0] a, b;
  } plan_t;

  exp_t  sbq[$];
  plan_t planq[$];

  logic        mVld = 1'b0;
  logic [1:0]  mOp;
  logic [31:0] mA, mB, mR;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, ".req_ready"}, req_ready, 1);
    chk({tag, ".fpu_start"}, fpu_start, 0);
    chk({tag, ".fpu_rst"}, fpu_rst, 0);
    chk({tag, ".wb_valid"}, wb_valid, 0);
    chk({tag, ".wb_err"}, wb_err, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".fpu_a"}, fpu_a, 0);
    chk({tag, ".fpu_b"}, fpu_b, 0);
    chk({tag, ".fpu_op"}, fpu_op, 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".wb_rd"}, wb_rd, 0);
  endtask

  // Issue one request; the reference outcome is queued at acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic hang, input int d,
                       input logic [31:0] res);
    exp_t  e;
    plan_t p;
    int    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 300) begin
      req_valid = 1'($urandom);
      req_a  = $urandom;
      req_b  = $urandom;
      req_op = 2'($urandom);
      req_rd = 5'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    e.rd = rd; e.op = op; e.a = a; e.b = b;
    if (REUSE && mVld && mOp == op && mA == a && mB == b) begin
      e.data = mR; e.err = 1'b0; e.lat = 0;
    end else begin
      mVld = 1'b0;
      p.hang = hang; p.d = d; p.res = res;
      p.op = op; p.a = a; p.b = b;
      planq.push_back(p);
      e.data = hang ? NAN : res;
      e.err  = hang;
      e.lat  = hang ? TMO + 3 : d + 1;
    end
    e.accept = cyc + 1;
    sbq.push_back(e);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // FPU model: done stays high after a result until well into the next op.
  task automatic fpuModel();
    plan_t p;
    forever begin
      @(negedge clk);
      if (fpu_start === 1'b1) begin
        if (planq.size() == 0) begin
          chk("unexpected_fpu_start", fpu_start, 0);
          continue;
        end
        p = planq.pop_front();
        chk("fpu_a", fpu_a, p.a);
        chk("fpu_b", fpu_b, p.b);
        chk("fpu_op", fpu_op, p.op);
        @(negedge clk);
        chk("fpu_start_pulse", fpu_start, 0);
        for (int j = 2; j < TMO + 8; j++) begin
          @(negedge clk);
          if (!p.hang && j >= p.d) begin
            fpu_done = 1'b1;
            fpu_r = p.res;
            break;
          end
          fpu_done = 1'b0;
          fpu_r = $urandom;
          if (p.hang && fpu_rst) break;
        end
      end
    end
  endtask

  task automatic monitor();
    logic prevV = 1'b0;
    int   rstRun = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("busy", busy, !req_ready);
      if (fpu_rst) rstRun++;
      else if (rstRun != 0) begin
        chk("fpu_rst_len", rstRun, 2);
        rstRun = 0;
      end
      if (wb_valid) begin
        if (sbq.size() == 0) chk("spurious_wb_valid", wb_valid, 0);
        else begin
          if (!prevV) chk("latency", cyc - sbq[0].accept, sbq[0].lat);
          chk("wb_rd", wb_rd, sbq[0].rd);
          chk("wb_data", wb_data, sbq[0].data);
          chk("wb_err", wb_err, sbq[0].err);
          chk("req_ready_in_wb", req_ready, 0);
          if (wb_ready) begin
            e = sbq.pop_front();
            if (!e.err) begin
              mVld = 1'b1; mOp = e.op; mA = e.a; mB = e.b; mR = e.data;
            end
          end
        end
      end
      prevV = wb_valid;
    end
  endtask

  task automatic wbReadyDrv();
    forever begin
      @(posedge clk); #1;
      wb_ready = ($urandom_range(0, 9) < 6);
    end
  endtask

  logic [1:0]  lOp;
  logic [31:0] lA, lB;

  initial begin
    int n;
    rst = 1'b0;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    fpu_done = 1'b0; fpu_r = '0; wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b1;

    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b10;
    req_a = 32'h11111111; req_b = 32'h22222222; req_rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("start_pulse", fpu_start, 1);
    chk("start_busy", busy, 1);
    chk("start_fpu_a", fpu_a, 32'h11111111);
    repeat (2) @(posedge clk);
    #1;
    chk("wait_busy", busy, 1);
    rst = 1'b0;
    #1;
    checkIdle("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_ready", req_ready, 1);
      chk("post_reset_nostart", fpu_start, 0);
    end

    fork
      fpuModel();
      monitor();
      wbReadyDrv();
    join_none

    issue(2'b00, 32'h3F800000, 32'h40000000, 5'd5, 1'b0, 5, 32'h40400000);
    issue(2'b00, 32'h3F800000, 32'h40000000, 5'd6, 1'b0, 4, 32'h40400000);
    issue(2'b01, 32'h3F800000, 32'h40000000, 5'd7, 1'b1, 0, 32'h0);
    issue(2'b00, 32'h3F800000, 32'h40000000, 5'd8, 1'b0, 6, 32'h40400000);
    issue(2'b00, 32'h3F800000, 32'h40000000, 5'd9, 1'b0, 2, 32'h40400000);
    lOp = 2'b00; lA = 32'h3F800000; lB = 32'h40000000;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      if ($urandom_range(0, 9) < 3) begin
        op = lOp; a = lA; b = lB;
      end else begin
        op = 2'($urandom); a = $urandom; b = $urandom;
      end
      lOp = op; lA = a; lB = b;
      issue(op, a, b, 5'($urandom), ($urandom_range(0, 9) == 0),
            $urandom_range(2, 9), $urandom);
    end

    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_sb", sbq.size(), 0);
    chk("drain_plans", planq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
